// File: rtl/cnt_array.sv
// cnt_array: NCH-channel up/down timer/counter with one-shot/auto-reload, W1C pending and per-channel interrupts
module cnt_array #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           xrst,
  input  logic           cs,
  input  logic           rw,
  input  logic [7:0]     addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata,
  output logic [NCH-1:0] irq,
  output logic           irq_any
);
  logic [NCH-1:0] en, arl, dn, ie, pend;
  logic [NCH-1:0] hit, term, wc, wl, wn, ws;
  logic [CW-1:0]  load [NCH];
  logic [CW-1:0]  cnt  [NCH];
  logic [31:0]    rd;
  logic           wr;
  logic [1:0]     sel;
  assign wr  = cs & rw;
  assign sel = addr[3:2];
  // A CNT write in the same cycle suppresses both the step and the terminal event
  always_comb begin
    rd   = '0;
    hit  = '0;
    term = '0;
    wc   = '0;
    wl   = '0;
    wn   = '0;
    ws   = '0;
    for (int k = 0; k < NCH; k++) begin
      hit[k]  = addr[7:4] == 4'(k) && addr[1:0] == 2'b00;
      wc[k]   = wr && hit[k] && sel == 2'd0;
      wl[k]   = wr && hit[k] && sel == 2'd1;
      wn[k]   = wr && hit[k] && sel == 2'd2;
      ws[k]   = wr && hit[k] && sel == 2'd3;
      term[k] = en[k] && !wn[k] && (dn[k] ? cnt[k] == '0 : cnt[k] == load[k]);
      if (hit[k])
        rd = sel == 2'd0 ? {28'b0, ie[k], dn[k], arl[k], en[k]} :
             sel == 2'd1 ? 32'(load[k]) :
             sel == 2'd2 ? 32'(cnt[k]) : {31'b0, pend[k]};
    end
  end
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      en    <= '0;
      arl   <= '0;
      dn    <= '0;
      ie    <= '0;
      pend  <= '0;
      rdata <= '0;
      for (int k = 0; k < NCH; k++) begin
        load[k] <= '0;
        cnt[k]  <= '0;
      end
    end else begin
      if (cs && !rw) rdata <= rd;
      for (int k = 0; k < NCH; k++) begin
        en[k]   <= wc[k] ? wdata[0] : (term[k] && !arl[k]) ? 1'b0 : en[k];
        arl[k]  <= wc[k] ? wdata[1] : arl[k];
        dn[k]   <= wc[k] ? wdata[2] : dn[k];
        ie[k]   <= wc[k] ? wdata[3] : ie[k];
        load[k] <= wl[k] ? wdata[CW-1:0] : load[k];
        cnt[k]  <= wn[k] ? wdata[CW-1:0] :
                   !en[k] ? cnt[k] :
                   term[k] ? (arl[k] ? (dn[k] ? load[k] : '0) : cnt[k]) :
                   dn[k] ? cnt[k] - 1'b1 : cnt[k] + 1'b1;
        pend[k] <= term[k] | (pend[k] & ~(ws[k] & wdata[0]));
      end
    end
  end
  assign irq     = pend & ie;
  assign irq_any = |irq;
endmodule

// File: tb/tb_cnt_array.sv
// tb_cnt_array: directed bus sequences; read expectations go through a scoreboard queue checked by a monitor
module tb_cnt_array;
  localparam int NCH = 4;
  localparam int CW  = 16;
  logic           clk = 1'b0;
  logic           xrst = 1'b1;
  logic           cs = 1'b0;
  logic           rw = 1'b0;
  logic [7:0]     addr = '0;
  logic [31:0]    wdata = '0;
  logic [31:0]    rdata;
  logic [NCH-1:0] irq;
  logic           irq_any;
  int             errors = 0;
  int             checks = 0;
  logic [31:0]    q_exp[$];
  string          q_name[$];

  cnt_array #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .xrst(xrst), .cs(cs), .rw(rw), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irq(irq), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Ops start on a negedge and end on the next one; the access happens at the posedge between
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    cs = 1'b1;
    rw = 1'b1;
    addr = {ch[3:0], r[3:0]};
    wdata = d;
    @(negedge clk);
    cs = 1'b0;
    rw = 1'b0;
  endtask

  task automatic rd(input int ch, input int r, input logic [31:0] e, input string n);
    cs = 1'b1;
    rw = 1'b0;
    addr = {ch[3:0], r[3:0]};
    q_exp.push_back(e);
    q_name.push_back(n);
    @(negedge clk);
    cs = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    if (cs && !rw && !xrst) begin
      @(negedge clk);
      if (q_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got %h expected none", rdata);
      end else begin
        chk(q_name.pop_front(), rdata, q_exp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_rdata", rdata, 0);
    chk("reset_irq", 32'(irq), 0);
    xrst = 1'b0;
    // up auto-reload with interrupt
    wr(0, 4, 3);
    wr(0, 8, 0);
    wr(0, 0, 'hB);
    rd(0, 8, 0, "t2_cnt_a");
    rd(0, 8, 1, "t2_cnt_b");
    rd(0, 8, 2, "t2_cnt_c");
    rd(0, 8, 3, "t2_cnt_d");
    rd(0, 8, 0, "t2_cnt_reload");
    chk("t2_irq_set", 32'(irq), 1);
    wr(0, 0, 8);
    wr(0, 'hC, 1);
    chk("t2_irq_clr", 32'(irq), 0);
    rd(0, 8, 2, "t2_cnt_hold");
    rd(0, 'hC, 0, "t2_stat");
    // down one-shot, interrupt masked
    wr(1, 4, 5);
    wr(1, 8, 2);
    wr(1, 0, 5);
    rd(1, 8, 2, "t3_cnt_a");
    rd(1, 8, 1, "t3_cnt_b");
    rd(1, 8, 0, "t3_cnt_c");
    rd(1, 8, 0, "t3_cnt_hold1");
    rd(1, 8, 0, "t3_cnt_hold2");
    rd(1, 0, 4, "t3_ctrl_en_off");
    rd(1, 'hC, 1, "t3_pend");
    chk("t3_irq_masked", 32'(irq), 0);
    // down auto-reload reloads from LOAD
    wr(1, 4, 2);
    wr(1, 8, 1);
    wr(1, 0, 7);
    rd(1, 8, 1, "t3b_cnt_a");
    rd(1, 8, 0, "t3b_cnt_b");
    rd(1, 8, 2, "t3b_reload");
    rd(1, 8, 1, "t3b_cnt_c");
    wr(1, 0, 0);
    // W1C in the terminal cycle, then CNT write against a step
    wr(3, 4, 2);
    wr(3, 8, 0);
    wr(3, 0, 1);
    rd(3, 8, 0, "t4_cnt_a");
    rd(3, 8, 1, "t4_cnt_b");
    wr(3, 'hC, 1);
    rd(3, 'hC, 1, "t4_w1c_vs_term");
    rd(3, 0, 0, "t4_oneshot_en");
    rd(3, 8, 2, "t4_cnt_held");
    wr(3, 4, 100);
    wr(3, 0, 1);
    wr(3, 8, 9);
    rd(3, 8, 9, "t4_cnt_write_wins");
    wr(3, 0, 0);
    // width and decode
    wr(1, 8, 'h1234ABCD);
    rd(1, 8, 'h0000ABCD, "t5_width");
    rd(4, 8, 0, "t5_ch_oob");
    rd(0, 2, 0, "t5_misaligned");
    wr(0, 'hA, 'h55);
    wr(4, 8, 'h77);
    rd(0, 8, 2, "t5_no_alias");
    rd(0, 4, 3, "t5_load");
    // two channels, disable colliding with terminal
    wr(0, 4, 1);
    wr(0, 8, 0);
    wr(2, 4, 2);
    wr(2, 8, 0);
    wr(0, 0, 'hB);
    wr(2, 0, 'hB);
    chk("t6_any_before", 32'(irq_any), 0);
    rd(2, 8, 0, "t6_cnt2");
    chk("t6_irq_ch0", 32'(irq), 1);
    chk("t6_any_ch0", 32'(irq_any), 1);
    wr(0, 0, 8);
    wr(2, 0, 8);
    chk("t6_irq_both", 32'(irq), 5);
    rd(2, 8, 0, "t6_reload_on_disable");
    rd(2, 0, 8, "t6_ctrl2");
    wr(0, 'hC, 1);
    chk("t6_irq_ch2", 32'(irq), 4);
    chk("t6_any_ch2", 32'(irq_any), 1);
    wr(2, 'hC, 1);
    chk("t6_any_clear", 32'(irq_any), 0);
    // asynchronous reset mid-run
    wr(0, 4, 0);
    wr(0, 8, 0);
    wr(0, 0, 'hB);
    rd(0, 0, 'hB, "t1_pre_ctrl");
    chk("t1_pre_irq", 32'(irq), 1);
    #2 xrst = 1'b1;
    #1;
    chk("t1_rdata_async", rdata, 0);
    chk("t1_irq_async", 32'(irq), 0);
    chk("t1_any_async", 32'(irq_any), 0);
    @(negedge clk);
    xrst = 1'b0;
    rd(0, 0, 0, "t1_ctrl");
    rd(0, 8, 0, "t1_cnt");
    rd(0, 'hC, 0, "t1_stat");
    repeat (2) @(negedge clk);
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d expected 0", q_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
